seq_signed_or_unsigned_mul: RTL and testbench

- Iterative radix-2 shift-add multiplier, parametrised in operand width n.
- Supports signed (two's complement) and unsigned operands, selected per operation.
- Replaces the combinational signed/unsigned multiplier where area matters more than latency.
- Sits between a valid/ready producer and consumer: one operation in flight, n-cycle compute.

---
 rtl/seq_signed_or_unsigned_mul.sv | 117 +++++++++++
 tb/tb_seq_signed_or_unsigned_mul.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_or_unsigned_mul.sv
// Iterative radix-2 shift-add multiplier with per-operation signed/unsigned mode.
// One operation in flight; n BUSY cycles between accept and result.
module seq_signed_or_unsigned_mul #(
  parameter int n = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic [n-1:0]     a,
  input  logic [n-1:0]     b,
  input  logic             signed_mul,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [2*n-1:0]   res
);

  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*n-1:0]  mcand_q, mcand_d;
  logic [n-1:0]    mplier_q, mplier_d;
  logic [2*n-1:0]  acc_q, acc_d;
  logic [2*n-1:0]  res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;

  logic [n-1:0]    a_mag;
  logic [n-1:0]    b_mag;
  logic [2*n-1:0]  acc_sum;

  // The magnitude of the most negative value (2^(n-1)) still fits in n unsigned bits.
  always_comb begin
    a_mag   = (signed_mul && a[n-1]) ? (-a) : a;
    b_mag   = (signed_mul && b[n-1]) ? (-b) : b;
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;

    case (state_q)
      IDLE: begin
        if (arg_vld) begin
          state_d  = BUSY;
          mcand_d  = {{n{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = signed_mul & (a[n-1] ^ b[n-1]);
        end
      end

      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(n - 1)) begin
          // Sign is reapplied once on the finished magnitude product.
          res_d   = neg_q ? (-acc_sum) : acc_sum;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (res_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign arg_rdy = (state_q == IDLE);
  assign res_vld = (state_q == DONE);
  assign res     = res_q;

endmodule

// File: tb/tb_seq_signed_or_unsigned_mul.sv
// Directed bench for seq_signed_or_unsigned_mul at n=4 and n=8.
// Expected products are hand-computed constants or integer arithmetic in the bench.
module tb_seq_signed_or_unsigned_mul;

  logic clk = 1'b0;
  logic rst;

  logic       arg_vld4, arg_rdy4, s4, res_vld4, res_rdy4;
  logic [3:0] a4, b4;
  logic [7:0] res4;

  logic        arg_vld8, arg_rdy8, s8, res_vld8, res_rdy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_signed_or_unsigned_mul #(.n(4)) dut4 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld4), .arg_rdy(arg_rdy4), .a(a4), .b(b4),
    .signed_mul(s4), .res_vld(res_vld4), .res_rdy(res_rdy4), .res(res4)
  );

  seq_signed_or_unsigned_mul #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld8), .arg_rdy(arg_rdy8), .a(a8), .b(b8),
    .signed_mul(s8), .res_vld(res_vld8), .res_rdy(res_rdy8), .res(res8)
  );

  // One n=4 operation: hold = DONE cycles with res_rdy low, scramble = disturb inputs in BUSY.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                     input logic [7:0] exp, input int hold, input bit scramble,
                     input string name);
    int lat;
    bit seen;
    @(negedge clk);
    res_rdy4 = (hold == 0);
    arg_vld4 = 1'b1; a4 = ta; b4 = tb; s4 = ts;
    vectors++;
    if (arg_rdy4 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle_rdy: arg_rdy=%b expected 1", name, arg_rdy4);
    end
    @(posedge clk); #1;
    arg_vld4 = 1'b0;
    if (scramble) begin
      a4 = 4'd7; b4 = 4'd7; s4 = 1'b0;
    end
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (res_vld4 === 1'b1) seen = 1;
      vectors++;
      if (arg_rdy4 !== 1'b0) begin
        miscompares++;
        $display("FAIL %s busy_rdy: arg_rdy=%b expected 0 at edge %0d", name, arg_rdy4, lat);
      end
    end
    vectors++;
    if (!seen || lat != 4) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges (seen=%0d) expected 4", name, lat, seen);
    end
    vectors++;
    if (res4 !== exp) begin
      miscompares++;
      $display("FAIL %s a=%h b=%h s=%b: res=%h expected %h", name, ta, tb, ts, res4, exp);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (res_vld4 !== 1'b1 || res4 !== exp) begin
        miscompares++;
        $display("FAIL %s hold%0d: res_vld=%b res=%h expected 1 %h", name, k, res_vld4, res4, exp);
      end
    end
    @(negedge clk);
    res_rdy4 = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (arg_rdy4 !== 1'b1 || res_vld4 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s handoff: arg_rdy=%b res_vld=%b expected 1 0", name, arg_rdy4, res_vld4);
    end
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                     input logic [15:0] exp, input string name);
    int lat;
    bit seen;
    @(negedge clk);
    res_rdy8 = 1'b1;
    arg_vld8 = 1'b1; a8 = ta; b8 = tb; s8 = ts;
    @(posedge clk); #1;
    arg_vld8 = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (res_vld8 === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen || lat != 8) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges (seen=%0d) expected 8", name, lat, seen);
    end
    vectors++;
    if (res8 !== exp) begin
      miscompares++;
      $display("FAIL %s: res=%h expected %h", name, res8, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    arg_vld4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; res_rdy4 = 1'b1;
    arg_vld8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; res_rdy8 = 1'b1;
    #12;
    vectors++;
    if (arg_rdy4 !== 1'b1 || res_vld4 !== 1'b0 || res4 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset4: rdy=%b vld=%b res=%h expected 1 0 00", arg_rdy4, res_vld4, res4);
    end
    vectors++;
    if (arg_rdy8 !== 1'b1 || res_vld8 !== 1'b0 || res8 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset8: rdy=%b vld=%b res=%h expected 1 0 0000", arg_rdy8, res_vld8, res8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exhaustive();
    int p;
    logic [3:0] av, bv;
    logic [7:0] e;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        p = i * j; av = i[3:0]; bv = j[3:0]; e = p[7:0];
        op4(av, bv, 1'b0, e, 0, 0, "exh_unsigned");
      end
    end
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        p = i * j; av = i[3:0]; bv = j[3:0]; e = p[7:0];
        op4(av, bv, 1'b1, e, 0, 0, "exh_signed");
      end
    end
  endtask

  task automatic test_corners();
    op4(4'hF, 4'hF, 1'b0, 8'hE1, 0, 0, "u15x15");
    op4(4'h8, 4'h8, 1'b1, 8'h40, 0, 0, "sm8xm8");
    op4(4'h8, 4'h7, 1'b1, 8'hC8, 0, 0, "sm8x7");
    op4(4'hF, 4'hF, 1'b1, 8'h01, 0, 0, "sm1xm1");
    op4(4'h0, 4'h8, 1'b1, 8'h00, 0, 0, "s0xm8");
  endtask

  // arg_vld held high: expect a 6-cycle pattern idle, 4x busy, done.
  task automatic test_back_to_back();
    int ph;
    @(negedge clk);
    res_rdy4 = 1'b1;
    arg_vld4 = 1'b1; a4 = 4'd3; b4 = 4'd4; s4 = 1'b0;
    for (int j = 0; j < 18; j++) begin
      if (j > 0) @(negedge clk);
      ph = j % 6;
      vectors++;
      if (arg_rdy4 !== (ph == 0) || res_vld4 !== (ph == 5)) begin
        miscompares++;
        $display("FAIL b2b cycle%0d: rdy=%b vld=%b expected %b %b",
                 j, arg_rdy4, res_vld4, (ph == 0), (ph == 5));
      end
      if (ph == 5) begin
        vectors++;
        if (res4 !== 8'h0C) begin
          miscompares++;
          $display("FAIL b2b res cycle%0d: res=%h expected 0c", j, res4);
        end
      end
    end
    arg_vld4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    op4(4'd3, 4'd5, 1'b0, 8'h0F, 5, 0, "backpressure");
  endtask

  task automatic test_isolation();
    op4(4'd2, 4'd3, 1'b1, 8'h06, 0, 1, "isolation");
  endtask

  task automatic test_reset_mid();
    bit stale;
    @(negedge clk);
    res_rdy4 = 1'b1;
    arg_vld4 = 1'b1; a4 = 4'd9; b4 = 4'd9; s4 = 1'b0;
    @(posedge clk); #1;
    arg_vld4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (arg_rdy4 !== 1'b1 || res_vld4 !== 1'b0 || res4 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid: rdy=%b vld=%b res=%h expected 1 0 00", arg_rdy4, res_vld4, res4);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (res_vld4 !== 1'b0 || arg_rdy4 !== 1'b1) stale = 1;
    end
    vectors++;
    if (stale) begin
      miscompares++;
      $display("FAIL reset_mid stale: res_vld/arg_rdy left idle after release, got 1 expected 0");
    end
    op4(4'd5, 4'd5, 1'b0, 8'h19, 0, 0, "after_reset");
  endtask

  task automatic test_n8();
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, "n8_m128x127");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "n8_m128xm128");
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "n8_u255x255");
  endtask

  initial begin
    test_reset();
    test_corners();
    test_exhaustive();
    test_back_to_back();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    test_n8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
